// File: rtl/dm_access_ctrl_if.sv
// Bundle of the CPU request/response channel and the word-only DM port seen by dm_access_ctrl.
// slave = the controller; master = the CPU side together with the DM that returns dm_rdata.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic        dm_R;
  logic        dm_W;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_R, dm_W, dm_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_R, dm_W, dm_wdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Byte-addressed load/store front end for a word-only data memory.
// Sub-word stores are done as read-modify-write; bad requests get an error response with no DM access.
module dm_access_ctrl #(
  parameter int DM_DEPTH_LOG2 = 8,
  parameter bit ERR_ON_OOR    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  dm_access_ctrl_if.slave  bus
);
  localparam int IW = DM_DEPTH_LOG2;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state_reg, state_next;
  logic          we_reg, we_next;
  logic [1:0]    size_reg, size_next;
  logic          uns_reg, uns_next;
  logic [IW+1:0] addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          err_reg, err_next;

  logic          acc_err;
  logic [31:0]   merged_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_ext;

  assign acc_err = (bus.req_size == 2'b11)
                 || (bus.req_size == SZ_HALF && bus.req_addr[0])
                 || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                 || (ERR_ON_OOR && ((bus.req_addr >> (IW + 2)) != 32'd0));

  // Merge the store lane(s) over the word read back from DM; word stores replace all lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       sel;
    logic [7:0] sbyte;
    assign sel = (size_reg == SZ_BYTE) ? (addr_reg[1:0] == LANE) :
                 (size_reg == SZ_HALF) ? (addr_reg[1] == LANE[1]) : 1'b1;
    assign sbyte = (size_reg == SZ_BYTE) ? wdata_reg[7:0] :
                   (size_reg == SZ_HALF) ? wdata_reg[8*(gi%2) +: 8] : wdata_reg[8*gi +: 8];
    assign merged_word[8*gi +: 8] = sel ? sbyte : bus.dm_rdata[8*gi +: 8];
  end

  // Alignment is already guaranteed, so shifting by the byte offset puts the lane at bit 0.
  assign rd_shift = bus.dm_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    load_ext = bus.dm_rdata;
    case (size_reg)
      SZ_BYTE: load_ext = {{24{~uns_reg & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_ext = {{16{~uns_reg & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = bus.dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      size_reg  <= size_next;
      uns_reg   <= uns_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    size_next  = size_reg;
    uns_next   = uns_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          we_next    = bus.req_we;
          size_next  = bus.req_size;
          uns_next   = bus.req_unsigned;
          addr_next  = bus.req_addr[IW+1:0];
          wdata_next = bus.req_wdata;
          rdata_next = '0;
          err_next   = acc_err;
          if (acc_err)
            state_next = RESP;
          else if (!bus.req_we || bus.req_size != SZ_WORD)
            state_next = READ;
          else
            state_next = WRITE;
        end
      end
      READ: begin
        if (we_reg) begin
          wdata_next = merged_word;
          state_next = WRITE;
        end else begin
          rdata_next = load_ext;
          state_next = RESP;
        end
      end
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is masked by rst so a pending write is dropped the moment reset arrives.
  assign bus.req_ready  = (state_reg == IDLE) && !rst;
  assign bus.dm_R       = (state_reg == READ) && !rst;
  assign bus.dm_W       = (state_reg == WRITE) && !rst;
  assign bus.dm_addr    = (bus.dm_R || bus.dm_W) ? 32'(addr_reg[IW+1:2]) : 32'd0;
  assign bus.dm_wdata   = bus.dm_W ? wdata_reg : 32'd0;
  assign bus.resp_valid = (state_reg == RESP) && !rst;
  assign bus.resp_err   = bus.resp_valid && err_reg;
  assign bus.resp_rdata = bus.resp_valid ? rdata_reg : 32'd0;
endmodule
